// File: rtl/quadrature_generator.sv
// Rotary encoder emulator: drives a/b quadrature and button lines from detent commands
// and press requests, with optional contact-bounce injection on every line edge.
`timescale 1ns/1ps
module quadrature_generator #(
    parameter int PHASE_CYCLES  = 1000,
    parameter int PRESS_CYCLES  = 70000,
    parameter int BOUNCE_EDGES  = 0,
    parameter int BOUNCE_CYCLES = 8
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_dir,
    input  logic [7:0] i_cmd_steps,
    output logic       o_cmd_done,
    input  logic       i_press_req,
    output logic       o_press_busy,
    output logic       o_a,
    output logic       o_b,
    output logic       o_button
);

    localparam int PW = $clog2(PHASE_CYCLES);
    localparam int KW = $clog2(PRESS_CYCLES);
    localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYCLES - 2);
    localparam logic [KW-1:0] PRESS_LAST = KW'(PRESS_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, HOLD, STEP, DONE} rot_state_t;
    typedef enum logic [1:0] {P_IDLE, P_HIGH, P_GUARD} press_state_t;

    rot_state_t   r_rot_state;
    press_state_t r_press_state;
    logic          r_dir;
    logic [7:0]    r_steps;
    logic [9:0]    r_remain;
    logic [PW-1:0] r_phase_cnt;
    logic          r_cmd_ready;
    logic          r_cmd_done;
    logic [KW-1:0] r_press_cnt;
    logic          r_press_busy;

    // Line index: 0 = a, 1 = b, 2 = button.
    logic [2:0] w_toggle;
    logic [2:0] w_line;
    logic [1:0] w_ab_ideal;
    logic       w_accept;
    logic       w_step;
    logic       w_ab_equal;

    assign w_accept   = i_cmd_valid && r_cmd_ready;
    assign w_step     = ((r_rot_state == LOAD) && (r_steps != 8'd0)) ||
                        ((r_rot_state == STEP) && (r_remain != 10'd0));
    assign w_ab_equal = (w_ab_ideal[0] == w_ab_ideal[1]);

    // Up walks 00->10->11->01: toggle a when a==b, otherwise b. Down is the mirror.
    always_comb begin
        w_toggle    = 3'b000;
        w_toggle[0] = w_step && (r_dir ? w_ab_equal : !w_ab_equal);
        w_toggle[1] = w_step && (r_dir ? !w_ab_equal : w_ab_equal);
        w_toggle[2] = ((r_press_state == P_IDLE) && i_press_req) ||
                      ((r_press_state == P_HIGH) && (r_press_cnt == PRESS_LAST));
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rot_state <= IDLE;
            r_dir       <= 1'b0;
            r_steps     <= 8'd0;
            r_remain    <= 10'd0;
            r_phase_cnt <= '0;
            r_cmd_ready <= 1'b1;
            r_cmd_done  <= 1'b0;
        end else begin
            case (r_rot_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dir       <= i_cmd_dir;
                        r_steps     <= i_cmd_steps;
                        r_cmd_ready <= 1'b0;
                        r_rot_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (r_steps == 8'd0) begin
                        r_cmd_done  <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_rot_state <= DONE;
                    end else begin
                        r_remain    <= {r_steps, 2'b00} - 10'd1;
                        r_phase_cnt <= '0;
                        r_rot_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_phase_cnt == PHASE_LAST) begin
                        r_rot_state <= STEP;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 1'b1;
                    end
                end
                STEP: begin
                    // The last transition still gets a full phase hold before done.
                    if (r_remain == 10'd0) begin
                        r_cmd_done  <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_rot_state <= DONE;
                    end else begin
                        r_remain    <= r_remain - 10'd1;
                        r_phase_cnt <= '0;
                        r_rot_state <= HOLD;
                    end
                end
                DONE: begin
                    r_cmd_done <= 1'b0;
                    if (w_accept) begin
                        r_dir       <= i_cmd_dir;
                        r_steps     <= i_cmd_steps;
                        r_cmd_ready <= 1'b0;
                        r_rot_state <= LOAD;
                    end else begin
                        r_rot_state <= IDLE;
                    end
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                    r_cmd_done  <= 1'b0;
                    r_rot_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_press_state <= P_IDLE;
            r_press_cnt   <= '0;
            r_press_busy  <= 1'b0;
        end else begin
            case (r_press_state)
                P_IDLE: begin
                    if (i_press_req) begin
                        r_press_busy  <= 1'b1;
                        r_press_cnt   <= '0;
                        r_press_state <= P_HIGH;
                    end
                end
                P_HIGH: begin
                    if (r_press_cnt == PRESS_LAST) begin
                        r_press_cnt   <= '0;
                        r_press_state <= P_GUARD;
                    end else begin
                        r_press_cnt <= r_press_cnt + 1'b1;
                    end
                end
                P_GUARD: begin
                    if (r_press_cnt == PRESS_LAST) begin
                        r_press_busy  <= 1'b0;
                        r_press_state <= P_IDLE;
                    end else begin
                        r_press_cnt <= r_press_cnt + 1'b1;
                    end
                end
                default: begin
                    r_press_busy  <= 1'b0;
                    r_press_state <= P_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_line
            logic r_ideal;
            if (gi < 2) begin : g_ab
                assign w_ab_ideal[gi] = r_ideal;
            end
            if (BOUNCE_EDGES > 0) begin : g_bounce
                localparam int SW = $clog2(BOUNCE_CYCLES + 1);
                localparam int HW = $clog2(2 * BOUNCE_EDGES + 1);
                localparam logic [SW-1:0] SUB_LAST  = SW'(BOUNCE_CYCLES - 1);
                localparam logic [HW-1:0] HALF_LAST = HW'(2 * BOUNCE_EDGES - 1);
                logic          r_line;
                logic          r_active;
                logic [SW-1:0] r_sub;
                logic [HW-1:0] r_half;

                // r_ideal moves on the first edge so phase timing is unaffected;
                // r_line alternates new/old every BOUNCE_CYCLES, ending on new.
                always_ff @(posedge i_clock or posedge i_reset) begin
                    if (i_reset) begin
                        r_ideal  <= 1'b0;
                        r_line   <= 1'b0;
                        r_active <= 1'b0;
                        r_sub    <= '0;
                        r_half   <= '0;
                    end else if (w_toggle[gi]) begin
                        r_ideal  <= ~r_ideal;
                        r_line   <= ~r_ideal;
                        r_active <= 1'b1;
                        r_sub    <= '0;
                        r_half   <= '0;
                    end else if (r_active) begin
                        if (r_sub == SUB_LAST) begin
                            r_sub <= '0;
                            if (r_half == HALF_LAST) begin
                                r_active <= 1'b0;
                                r_line   <= r_ideal;
                            end else begin
                                r_half <= r_half + 1'b1;
                                r_line <= ~r_line;
                            end
                        end else begin
                            r_sub <= r_sub + 1'b1;
                        end
                    end
                end
                assign w_line[gi] = r_line;
            end else begin : g_clean
                always_ff @(posedge i_clock or posedge i_reset) begin
                    if (i_reset) begin
                        r_ideal <= 1'b0;
                    end else if (w_toggle[gi]) begin
                        r_ideal <= ~r_ideal;
                    end
                end
                assign w_line[gi] = r_ideal;
            end
        end
    endgenerate

    assign o_cmd_ready  = r_cmd_ready;
    assign o_cmd_done   = r_cmd_done;
    assign o_press_busy = r_press_busy;
    assign o_a          = w_line[0];
    assign o_b          = w_line[1];
    assign o_button     = w_line[2];

endmodule

// File: tb/tb_quadrature_generator.sv
// Bench for quadrature_generator: a plain instance and a bouncing instance, each
// checked cycle by cycle against expected line levels derived from detent timing.
`timescale 1ns/1ps
module tb_quadrature_generator;

    localparam int P1  = 4;
    localparam int PR1 = 30;
    localparam int P2  = 20;
    localparam int PR2 = 40;
    localparam int BE2 = 2;
    localparam int BC2 = 2;

    int total = 0;
    int bad   = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid1 = 1'b0, dir1 = 1'b0, press1 = 1'b0;
    logic [7:0] steps1 = 8'd0;
    logic       ready1, done1, busy1, a1, b1, btn1;
    logic       valid2 = 1'b0, dir2 = 1'b0, press2 = 1'b0;
    logic [7:0] steps2 = 8'd0;
    logic       ready2, done2, busy2, a2, b2, btn2;

    always #5 clk = ~clk;

    quadrature_generator #(
        .PHASE_CYCLES(P1), .PRESS_CYCLES(PR1), .BOUNCE_EDGES(0), .BOUNCE_CYCLES(8)
    ) u_dut (
        .i_clock(clk), .i_reset(rst), .i_cmd_valid(valid1), .o_cmd_ready(ready1),
        .i_cmd_dir(dir1), .i_cmd_steps(steps1), .o_cmd_done(done1),
        .i_press_req(press1), .o_press_busy(busy1), .o_a(a1), .o_b(b1), .o_button(btn1)
    );

    quadrature_generator #(
        .PHASE_CYCLES(P2), .PRESS_CYCLES(PR2), .BOUNCE_EDGES(BE2), .BOUNCE_CYCLES(BC2)
    ) u_bnc (
        .i_clock(clk), .i_reset(rst), .i_cmd_valid(valid2), .o_cmd_ready(ready2),
        .i_cmd_dir(dir2), .i_cmd_steps(steps2), .o_cmd_done(done2),
        .i_press_req(press2), .o_press_busy(busy2), .o_a(a2), .o_b(b2), .o_button(btn2)
    );

    // Encoder position (mod 4) to {a,b}: up sequence 00,10,11,01.
    function automatic logic [1:0] gray(input int p);
        case (p & 3)
            0: return 2'b00;
            1: return 2'b10;
            2: return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // Expected {a,b} in the cycle after edge T+j, command accepted at edge T.
    function automatic logic [1:0] exp_ab(input bit dir, input int steps, input int ph,
                                          input int be, input int bc, input int j);
        int n;
        int d;
        n = (j < 1) ? 0 : (j - 1) / ph + 1;
        if (n > 4 * steps) n = 4 * steps;
        if (n == 0) return 2'b00;
        d = j - (1 + (n - 1) * ph);
        if (be > 0 && d < 2 * be * bc) begin
            if (((d / bc) % 2) == 1) return gray(dir ? (n - 1) : -(n - 1));
        end
        return gray(dir ? n : -n);
    endfunction

    // Expected button level on the bouncing instance, press accepted at edge R.
    function automatic logic exp_btn(input int j);
        logic nv;
        int   d;
        if (j < PR2) begin nv = 1'b1; d = j; end
        else begin nv = 1'b0; d = j - PR2; end
        if (d < 2 * BE2 * BC2 && ((d / BC2) % 2) == 1) return !nv;
        return nv;
    endfunction

    // Called at a negedge with the plain instance ready; returns at the done-cycle negedge.
    task automatic drive_cmd(input bit dir, input int steps, input int abort_at);
        int last;
        logic [1:0] e_ab;
        last = 1 + 4 * steps * P1;
        total++;
        if (ready1 !== 1'b1) begin
            bad++; $display("FAIL cmd_ready_before_accept got=%b want=1", ready1);
        end
        valid1 = 1'b1; dir1 = dir; steps1 = 8'(steps);
        @(posedge clk); #1;
        valid1 = 1'b0; dir1 = 1'($urandom); steps1 = 8'($urandom);
        for (int j = 0; j <= last; j++) begin
            @(negedge clk);
            e_ab = exp_ab(dir, steps, P1, 0, 1, j);
            total++;
            if ({a1, b1} !== e_ab) begin
                bad++; $display("FAIL ab dir=%0d steps=%0d j=%0d got=%b want=%b", dir, steps, j, {a1, b1}, e_ab);
            end
            total++;
            if (done1 !== (j == last)) begin
                bad++; $display("FAIL cmd_done dir=%0d steps=%0d j=%0d got=%b want=%b", dir, steps, j, done1, (j == last));
            end
            total++;
            if (ready1 !== (j == last)) begin
                bad++; $display("FAIL cmd_ready dir=%0d steps=%0d j=%0d got=%b want=%b", dir, steps, j, ready1, (j == last));
            end
            if (j == abort_at) begin
                rst = 1'b1;
                return;
            end
            // A stray request while busy must be ignored.
            valid1 = (last >= 4 && j == last / 2);
        end
        $display("cmd dir=%0d steps=%0d checked over %0d cycles", dir, steps, last + 1);
    endtask

    task automatic test_reset_values;
        repeat (2) @(negedge clk);
        total++;
        if ({a1, b1, btn1, ready1, done1, busy1} !== 6'b000100) begin
            bad++; $display("FAIL reset_plain got=%b want=000100", {a1, b1, btn1, ready1, done1, busy1});
        end
        total++;
        if ({a2, b2, btn2, ready2, done2, busy2} !== 6'b000100) begin
            bad++; $display("FAIL reset_bounce got=%b want=000100", {a2, b2, btn2, ready2, done2, busy2});
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({a1, b1, btn1, ready1, done1, busy1} !== 6'b000100) begin
                bad++; $display("FAIL idle_after_reset got=%b want=000100", {a1, b1, btn1, ready1, done1, busy1});
            end
        end
        $display("reset values checked");
    endtask

    task automatic test_back_to_back;
        drive_cmd(1'b1, 3, -1);
        drive_cmd(1'b0, 2, -1);
        drive_cmd(1'b1, 0, -1);
        drive_cmd(1'b0, 0, -1);
        drive_cmd(1'b0, 1, -1);
    endtask

    task automatic test_press(input int second_at);
        total++;
        if (busy1 !== 1'b0) begin
            bad++; $display("FAIL press_busy_before got=%b want=0", busy1);
        end
        press1 = 1'b1;
        @(posedge clk); #1;
        press1 = 1'b0;
        for (int j = 0; j <= 2 * PR1; j++) begin
            @(negedge clk);
            total++;
            if (btn1 !== (j < PR1)) begin
                bad++; $display("FAIL button j=%0d got=%b want=%b", j, btn1, (j < PR1));
            end
            total++;
            if (busy1 !== (j < 2 * PR1)) begin
                bad++; $display("FAIL press_busy j=%0d got=%b want=%b", j, busy1, (j < 2 * PR1));
            end
            press1 = (j == second_at);
        end
        $display("press with extra request at %0d checked", second_at);
    endtask

    task automatic test_concurrent;
        fork
            test_press(20);
            drive_cmd(1'b0, 3, -1);
        join
    endtask

    task automatic test_random;
        int gap;
        for (int t = 0; t < 8; t++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                total++;
                if ({a1, b1, ready1, done1} !== 4'b0010) begin
                    bad++; $display("FAIL idle_gap got=%b want=0010", {a1, b1, ready1, done1});
                end
            end
            drive_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 5), -1);
        end
    endtask

    task automatic test_reset_mid;
        drive_cmd(1'b1, 2, 1 + P1 + 2);
        #1;
        total++;
        if ({a1, b1, ready1, done1} !== 4'b0010) begin
            bad++; $display("FAIL async_reset got=%b want=0010", {a1, b1, ready1, done1});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            total++;
            if ({a1, b1, ready1, done1} !== 4'b0010) begin
                bad++; $display("FAIL after_reset j=%0d got=%b want=0010", j, {a1, b1, ready1, done1});
            end
        end
        $display("mid-detent reset checked");
        drive_cmd(1'b1, 1, -1);
    endtask

    task automatic test_bounce;
        int last;
        logic [1:0] e_ab;
        bit dir;
        last = 1 + 4 * P2;
        for (int c = 0; c < 2; c++) begin
            dir = (c == 0);
            total++;
            if (ready2 !== 1'b1) begin
                bad++; $display("FAIL bounce_ready_before got=%b want=1", ready2);
            end
            valid2 = 1'b1; dir2 = dir; steps2 = 8'd1;
            @(posedge clk); #1;
            valid2 = 1'b0; steps2 = 8'($urandom);
            for (int j = 0; j <= last; j++) begin
                @(negedge clk);
                e_ab = exp_ab(dir, 1, P2, BE2, BC2, j);
                total++;
                if ({a2, b2} !== e_ab) begin
                    bad++; $display("FAIL bounce_ab dir=%0d j=%0d got=%b want=%b", dir, j, {a2, b2}, e_ab);
                end
                total++;
                if (done2 !== (j == last)) begin
                    bad++; $display("FAIL bounce_done dir=%0d j=%0d got=%b want=%b", dir, j, done2, (j == last));
                end
            end
            $display("bounce detent dir=%0d checked", dir);
        end
        press2 = 1'b1;
        @(posedge clk); #1;
        press2 = 1'b0;
        for (int j = 0; j <= 2 * PR2; j++) begin
            @(negedge clk);
            total++;
            if (btn2 !== exp_btn(j)) begin
                bad++; $display("FAIL bounce_button j=%0d got=%b want=%b", j, btn2, exp_btn(j));
            end
            total++;
            if (busy2 !== (j < 2 * PR2)) begin
                bad++; $display("FAIL bounce_busy j=%0d got=%b want=%b", j, busy2, (j < 2 * PR2));
            end
        end
        $display("bounce press checked");
    endtask

    initial begin
        test_reset_values;
        test_back_to_back;
        test_press(10);
        test_press(PR1 + 5);
        test_concurrent;
        test_random;
        test_reset_mid;
        test_bounce;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
